// File: rtl/srs_cs_seq.sv
// SRS per-port cyclic-shift sequencer: takes one config and streams
// n_cs,i = (n_cs + floor(max*i/N)) mod max, one antenna port per beat.
module srs_cs_seq #(
   parameter int MAX_AP = 4,
   parameter int CS_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            cfg_vld,
   output logic            cfg_rdy,
   input  logic [1:0]      cfg_ktc,
   input  logic [1:0]      cfg_ap_log2,
   input  logic [CS_W-1:0] cfg_cs,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [2:0]      out_port,
   output logic [CS_W-1:0] out_cs,
   output logic            out_last,
   output logic            cfg_err
);

   localparam int   AW     = 7;
   localparam logic ALLOW8 = (MAX_AP >= 8);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q;
   logic            rdy_q, vld_q, last_q, err_q;
   logic [2:0]      port_q, last_port_q;
   logic [CS_W-1:0] cs_q, max_q, base_q;
   logic [1:0]      shift_q;
   logic [AW-1:0]   acc_q;

   logic [CS_W-1:0] cfg_max;
   logic [AW-1:0]   cs_ext, max_ext, r1, r2, off_full, sum, res;
   logic [3:0]      n_ports;
   logic [2:0]      cfg_last_port;
   logic            cfg_legal, cfg_fire, out_fire;
   logic            unused_bits;

   always_comb begin
      case (cfg_ktc)
         2'd0:    cfg_max = CS_W'(8);
         2'd1:    cfg_max = CS_W'(12);
         default: cfg_max = CS_W'(6);
      endcase
      // cfg_cs < 3*max for every comb, so two conditional subtracts reduce it fully
      cs_ext   = AW'(cfg_cs);
      max_ext  = AW'(cfg_max);
      r1       = (cs_ext >= max_ext) ? cs_ext - max_ext : cs_ext;
      r2       = (r1 >= max_ext) ? r1 - max_ext : r1;
      off_full = acc_q >> shift_q;
      sum      = AW'(base_q) + off_full;
      res      = (sum >= AW'(max_q)) ? sum - AW'(max_q) : sum;
   end

   assign unused_bits   = ^{r2[AW-1:CS_W], res[AW-1:CS_W]};
   assign n_ports       = 4'd1 << cfg_ap_log2;
   assign cfg_last_port = 3'(n_ports - 4'd1);
   assign cfg_legal     = (cfg_ktc != 2'd3) && (ALLOW8 || (cfg_ap_log2 != 2'd3));
   assign cfg_rdy       = rdy_q & ~flush;
   assign cfg_fire      = cfg_rdy & cfg_vld;
   assign out_fire      = vld_q & out_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         vld_q       <= 1'b0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         port_q      <= '0;
         last_port_q <= '0;
         cs_q        <= '0;
         max_q       <= '0;
         base_q      <= '0;
         shift_q     <= '0;
         acc_q       <= '0;
      end else begin
         err_q <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  rdy_q <= 1'b1;
                  if (cfg_fire) begin
                     if (cfg_legal) begin
                        state_q     <= RUN;
                        rdy_q       <= 1'b0;
                        vld_q       <= 1'b1;
                        port_q      <= 3'd0;
                        cs_q        <= r2[CS_W-1:0];
                        last_q      <= (cfg_ap_log2 == 2'd0);
                        last_port_q <= cfg_last_port;
                        max_q       <= cfg_max;
                        base_q      <= r2[CS_W-1:0];
                        shift_q     <= cfg_ap_log2;
                        acc_q       <= max_ext;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (out_fire) begin
                     if (last_q) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                        vld_q   <= 1'b0;
                        last_q  <= 1'b0;
                        acc_q   <= '0;
                     end else begin
                        // acc_q already holds max*(port+1) for the port being presented next
                        port_q <= port_q + 3'd1;
                        cs_q   <= res[CS_W-1:0];
                        last_q <= ((port_q + 3'd1) == last_port_q);
                        acc_q  <= acc_q + AW'(max_q);
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign out_vld  = vld_q;
   assign out_port = port_q;
   assign out_cs   = cs_q;
   assign out_last = last_q;
   assign cfg_err  = err_q;

endmodule

// File: tb/tb_srs_cs_seq.sv
// Bench for srs_cs_seq: a MAX_AP=4 and a MAX_AP=8 instance share stimulus and are
// checked against an arithmetic model of the cyclic-shift sequence.
module tb_srs_cs_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       cfg_vld = 1'b0;
   logic       out_rdy = 1'b0;
   logic [1:0] cfg_ktc = 2'd0;
   logic [1:0] cfg_ap_log2 = 2'd0;
   logic [3:0] cfg_cs = 4'd0;

   logic       o_crdy [2];
   logic       o_vld  [2];
   logic       o_last [2];
   logic       o_err  [2];
   logic [2:0] o_port [2];
   logic [3:0] o_cs   [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   srs_cs_seq #(.MAX_AP(4), .CS_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .cfg_vld(cfg_vld), .cfg_rdy(o_crdy[0]), .cfg_ktc(cfg_ktc),
      .cfg_ap_log2(cfg_ap_log2), .cfg_cs(cfg_cs),
      .out_vld(o_vld[0]), .out_rdy(out_rdy), .out_port(o_port[0]),
      .out_cs(o_cs[0]), .out_last(o_last[0]), .cfg_err(o_err[0])
   );

   srs_cs_seq #(.MAX_AP(8), .CS_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .cfg_vld(cfg_vld), .cfg_rdy(o_crdy[1]), .cfg_ktc(cfg_ktc),
      .cfg_ap_log2(cfg_ap_log2), .cfg_cs(cfg_cs),
      .out_vld(o_vld[1]), .out_rdy(out_rdy), .out_port(o_port[1]),
      .out_cs(o_cs[1]), .out_last(o_last[1]), .cfg_err(o_err[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int comb_max(input int ktc);
      return (ktc == 0) ? 8 : (ktc == 1) ? 12 : 6;
   endfunction

   // d=0 is the MAX_AP=4 instance, d=1 the MAX_AP=8 instance
   function automatic bit is_legal(input int ktc, input int ap, input int d);
      return (ktc != 3) && ((d == 1) || (ap != 3));
   endfunction

   function automatic int exp_cs(input int ktc, input int ap, input int cs, input int k);
      int m;
      int n;
      m = comb_max(ktc);
      n = 1 << ap;
      return (cs + (m * k) / n) % m;
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at the falling edge of the cycle after the handshake.
   task automatic send_cfg(input int ktc, input int ap, input int cs);
      int w;
      w = 0;
      while (!(o_crdy[0] && o_crdy[1]) && w < 50) begin
         cycle();
         w++;
      end
      check("cfg_rdy4_idle", o_crdy[0], 1);
      check("cfg_rdy8_idle", o_crdy[1], 1);
      cfg_ktc     = 2'(ktc);
      cfg_ap_log2 = 2'(ap);
      cfg_cs      = 4'(cs);
      cfg_vld     = 1'b1;
      cycle();
      cfg_vld = 1'b0;
   endtask

   task automatic run_cfg(input int ktc, input int ap, input int cs, input bit bp);
      int cnt [2];
      int en  [2];
      int errs[2];
      int cycles;
      send_cfg(ktc, ap, cs);
      for (int d = 0; d < 2; d++) begin
         cnt[d]  = 0;
         en[d]   = is_legal(ktc, ap, d) ? (1 << ap) : 0;
         errs[d] = o_err[d] ? 1 : 0;
         check($sformatf("d%0d_first_vld", d), o_vld[d], is_legal(ktc, ap, d));
      end
      cycles = 0;
      while ((cnt[0] < en[0] || cnt[1] < en[1] || o_vld[0] || o_vld[1]) && cycles < 300) begin
         out_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int d = 0; d < 2; d++) begin
            if (o_vld[d]) begin
               check($sformatf("d%0d_no_extra", d), (cnt[d] < en[d]), 1);
               check($sformatf("d%0d_port", d), o_port[d], cnt[d]);
               check($sformatf("d%0d_cs", d), o_cs[d], exp_cs(ktc, ap, cs, cnt[d]));
               check($sformatf("d%0d_last", d), o_last[d], (cnt[d] == en[d] - 1));
               check($sformatf("d%0d_rdy_busy", d), o_crdy[d], 0);
               if (out_rdy) cnt[d]++;
            end
         end
         cycle();
         cycles++;
         for (int d = 0; d < 2; d++) if (o_err[d]) errs[d]++;
      end
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_beat_count", d), cnt[d], en[d]);
         check($sformatf("d%0d_err_pulses", d), errs[d], is_legal(ktc, ap, d) ? 0 : 1);
      end
      $display("[TB] cfg ktc=%0d ap_log2=%0d cs=%0d bp=%0d beats4=%0d beats8=%0d err4=%0d err8=%0d",
               ktc, ap, cs, bp, cnt[0], cnt[1], errs[0], errs[1]);
   endtask

   initial begin
      // Reset values, then cfg_rdy rises once reset is released
      #12;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_rst_rdy", d), o_crdy[d], 0);
         check($sformatf("d%0d_rst_vld", d), o_vld[d], 0);
         check($sformatf("d%0d_rst_port", d), o_port[d], 0);
         check($sformatf("d%0d_rst_cs", d), o_cs[d], 0);
         check($sformatf("d%0d_rst_last", d), o_last[d], 0);
         check($sformatf("d%0d_rst_err", d), o_err[d], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check("rdy4_after_rst", o_crdy[0], 1);
      check("rdy8_after_rst", o_crdy[1], 1);

      // Directed configurations
      run_cfg(1, 2, 11, 1'b0);
      run_cfg(2, 2, 15, 1'b0);
      run_cfg(0, 1, 5, 1'b0);
      run_cfg(0, 0, 9, 1'b0);
      run_cfg(1, 3, 0, 1'b1);
      run_cfg(3, 1, 4, 1'b0);
      run_cfg(3, 3, 7, 1'b0);

      // Flush while port 2 is presented; the beat must be dropped
      send_cfg(1, 2, 11);
      out_rdy = 1'b1;
      cycle();
      cycle();
      check("flush_pre_port", o_port[1], 2);
      check("flush_pre_cs", o_cs[1], 5);
      flush = 1'b1;
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_flush_vld", d), o_vld[d], 0);
         check($sformatf("d%0d_flush_rdy_low", d), o_crdy[d], 0);
      end
      // An illegal config offered during flush must not be accepted (no cfg_err)
      cfg_ktc = 2'd3;
      cfg_vld = 1'b1;
      cycle();
      cfg_vld = 1'b0;
      flush   = 1'b0;
      for (int d = 0; d < 2; d++) check($sformatf("d%0d_flush_block", d), o_err[d], 0);
      #1;
      for (int d = 0; d < 2; d++) check($sformatf("d%0d_rdy_post_flush", d), o_crdy[d], 1);
      @(negedge clk);
      $display("[TB] flush mid-run done");
      run_cfg(1, 2, 11, 1'b0);

      // Asynchronous reset in the middle of a run
      send_cfg(0, 2, 3);
      out_rdy = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_mid_rst_vld", d), o_vld[d], 0);
         check($sformatf("d%0d_mid_rst_port", d), o_port[d], 0);
         check($sformatf("d%0d_mid_rst_cs", d), o_cs[d], 0);
         check($sformatf("d%0d_mid_rst_last", d), o_last[d], 0);
         check($sformatf("d%0d_mid_rst_rdy", d), o_crdy[d], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_rdy_after_mid_rst", d), o_crdy[d], 1);
         check($sformatf("d%0d_vld_after_mid_rst", d), o_vld[d], 0);
      end
      $display("[TB] reset mid-run done");

      // Randomised configurations with random back-pressure
      for (int t = 0; t < 24; t++) begin
         run_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
